// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM encoding and round helpers.
// Byte k of any 128-bit bus lives at [127-8k -: 8]; column c = bytes 4c..4c+3,
// row r of column c = byte 4c+r.
package aes_pkg;
  localparam int NR = 10;
  localparam int NK = 4;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

  // MSB position of byte k.
  function automatic logic [6:0] bidx(input int k);
    return 7'(127 - 8 * k);
  endfunction

  // Round constants, valid for rounds 1..10.
  function automatic logic [7:0] rcon_lut(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[bidx(4*c+r) -: 8] = s[bidx(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  // Row r of each output column: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[bidx(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[bidx(4*c+r) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                            ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction
endpackage

// File: rtl/key_expand_step.sv
// key_expand_step: one AES-128 round-key expansion step (combinational).
//   rk_prev [127:0] previous round key, rcon [7:0] round constant,
//   rk_next [127:0] next round key.
module key_expand_step (
  input  logic [127:0] rk_prev,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_next
);
  logic [31:0] w0, w1, w2, w3, rot, sub, t;

  assign {w0, w1, w2, w3} = rk_prev;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (.a_i(rot[31-8*i -: 8]), .y_o(sub[31-8*i -: 8]));
  end

  assign t = sub ^ {rcon, 24'h0};

  // Each new word chains off the one just produced.
  logic [31:0] n0, n1, n2, n3;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};
endmodule

// File: rtl/sbox.sv
// sbox: combinational AES forward S-box.
//   a_i [7:0] input byte, y_o [7:0] substituted byte.
module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y_o = TBL[a_i];
endmodule

// File: rtl/subbytes.sv
// subbytes: byte-wise S-box substitution over a 128-bit state.
//   state_i [127:0] input state, state_o [127:0] substituted state.
module subbytes
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);
  for (genvar k = 0; k < 16; k++) begin : g_byte
    sbox u_sbox (.a_i(state_i[127-8*k -: 8]), .y_o(state_o[127-8*k -: 8]));
  end
endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryptor, one full round per clock.
//   clk, rst_n (synchronous, active-high)
//   in_valid/in_ready, plaintext, key   : input handshake, accepted only in IDLE
//   out_valid/out_ready, ciphertext     : result handshake, held in DONE
// Latency: accept in cycle t, out_valid from cycle t+11.
module aes_round_engine #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);
  import aes_pkg::*;

  fsm_e         fsm_q;
  logic         in_ready_q, out_valid_q;
  logic [127:0] state_q, rk_q, ct_q;
  logic [3:0]   round_q;

  logic [127:0] sb, sr, mc, rk_next;
  logic [7:0]   rc;

  assign rc = rcon_lut(round_q);

  subbytes u_subbytes (.state_i(state_q), .state_o(sb));

  key_expand_step u_key (.rk_prev(rk_q), .rcon(rc), .rk_next(rk_next));

  assign sr = shift_rows(sb);
  assign mc = mix_columns(sr);

  // Handshake flags are registered alongside the FSM so neither output
  // depends combinationally on in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      fsm_q       <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      state_q     <= '0;
      rk_q        <= '0;
      ct_q        <= '0;
      round_q     <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: if (in_valid) begin
          state_q    <= plaintext ^ key;
          rk_q       <= key;
          round_q    <= 4'd1;
          fsm_q      <= S_ROUND;
          in_ready_q <= 1'b0;
        end
        S_ROUND: begin
          rk_q <= rk_next;
          if (round_q == 4'(NR)) begin
            // Final round skips MixColumns.
            ct_q        <= sr ^ rk_next;
            fsm_q       <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            state_q <= mc ^ rk_next;
            round_q <= round_q + 4'd1;
          end
        end
        S_DONE: if (out_ready) begin
          fsm_q       <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          fsm_q       <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
endmodule

// File: doc/aes_round_engine.md
# aes_round_engine

Iterative AES-128 encryption engine: accepts one plaintext/key pair over a valid/ready handshake, runs one full AES round per clock (SubBytes → ShiftRows → MixColumns → AddRoundKey) with on-the-fly key expansion, and returns the ciphertext over a second valid/ready handshake. It is the stage directly downstream of `subbytes`: it instantiates `subbytes` on its registered state and consumes its output every round cycle.

## Interface
Parameters:
- `NR`, 10: number of rounds; fixed for AES-128, not user-overridable in practice.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-high (asserted = 1), name kept per codebase convention.
- `in_valid`  in  1  plaintext/key pair valid.
- `in_ready`  out  1  engine can accept a pair; high only in IDLE.
- `plaintext`  in  128  input block.
- `key`  in  128  cipher key.
- `out_valid`  out  1  `ciphertext` valid.
- `out_ready`  in  1  downstream accepts ciphertext.
- `ciphertext`  out  128  result register.

Byte order, all 128-bit buses: FIPS-197 byte k (k = 0..15) at bits [127-8k -: 8]; column c = bytes 4c..4c+3; row r of column c = byte 4c+r.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE: `in_ready` = 1. On `in_valid && in_ready`: `state_q <= plaintext ^ key`, `rk_q <= key`, `round_q <= 1`, go ROUND. `in_valid` without acceptance has no effect.
- ROUND, each cycle:
  - `rk_next` = key-expansion step of `rk_q` using `rcon[round_q]` (01,02,04,08,10,20,40,80,1b,36).
  - `sb` = `subbytes(state_q)`; `sr` = ShiftRows(`sb`) (row r rotated left by r columns).
  - `round_q < NR`: `state_q <= MixColumns(sr) ^ rk_next`; `round_q <= round_q + 1`.
  - `round_q == NR`: `ciphertext <= sr ^ rk_next` (no MixColumns); go DONE.
  - `rk_q <= rk_next`.
- DONE: `out_valid` = 1, `ciphertext` stable. On `out_ready`: go IDLE. `in_valid` ignored while not IDLE.
- MixColumns arithmetic in GF(2^8), polynomial 0x11b; `xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00)`.
- `round_q` is 4 bits; it never exceeds NR and never wraps.

## Timing
- Reset (`rst_n` = 1 at an edge): FSM → IDLE; `in_ready` = 1 next cycle; `out_valid` = 0; `ciphertext`, `state_q`, `rk_q` = 0; `round_q` = 0. Reset has priority over every other event.
- Reset mid-ROUND or in DONE: computation abandoned, no `out_valid` pulse, pending result lost.
- Latency: acceptance in cycle t → ROUND in cycles t+1..t+10 → `out_valid` high from cycle t+11.
- `out_valid` holds until the `out_ready` cycle. If `out_ready` is high in the first DONE cycle, IDLE follows in the next cycle.
- Minimum period between acceptances: 12 cycles.
- `ciphertext` keeps its last value after the handshake until overwritten by the next completion.
- `in_ready` and `out_valid` are decoded from registered FSM state only. Neither has a combinational path from `in_valid` or `out_ready`.

## Structure
- Package `aes_pkg`:
  - `NR`, `NK` = 4.
  - FSM state enum.
  - `rcon` table indexed 1..10.
  - functions `xtime`, `shift_rows`, `mix_columns`, and a byte-index helper implementing the ordering above.
- Sub-module `key_expand_step`: combinational, input `rk_prev[127:0]` and `rcon[7:0]`, output `rk_next[127:0]`.
  - RotWord, then SubWord via 4 `sbox` instances, then XOR with rcon.
  - Then the chained word XORs w4..w7.
- The top instantiates one `subbytes` and one `key_expand_step`. The remainder is FSM, counter and registers, roughly 200 lines.

## Test plan
- FIPS-197 C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, `out_ready`=1 → `out_valid` at t+11, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Probe `state_q` at t+1: 193de3bea0f4e22b9ac68d2ae9f84808.
  - Final ciphertext: 3925841d02dc09fbdc118597196a0b32.
- Back-pressure: `out_ready`=0 for 5 cycles after completion → `out_valid` and `ciphertext` stable throughout, `in_ready`=0. Raise `out_ready` → IDLE the next cycle.
- Busy input: pulse `in_valid` with a different pt at t+4 → ignored; the C.1 result is unchanged.
- Reset mid-operation: assert `rst_n` at t+6 → next cycle `in_ready`=1, `out_valid`=0, `ciphertext`=0. A fresh C.1 run then completes correctly.
- Back-to-back: C.1 then App. B with `in_valid` held high and `out_ready`=1 → second acceptance 12 cycles after the first, both results correct.
